// File: rtl/rf_pkg.sv
// Register-file shared definitions.
// Purpose : address/data/tag typedefs and the hard-wired zero register
//           address, shared by the read-port controller and the regfile
//           wrapper so both agree on widths.
// Contents: RF_ROWS, RF_ADDR_WIDTH, RF_DATA_WIDTH, RF_TAG_WIDTH,
//           rf_addr_t, rf_data_t, rf_tag_t, RF_ZERO_ADDR.
package rf_pkg;

    localparam int RF_ROWS       = 32;
    localparam int RF_ADDR_WIDTH = $clog2(RF_ROWS);
    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_TAG_WIDTH  = 4;

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;
    typedef logic [RF_TAG_WIDTH-1:0]  rf_tag_t;

    // r0 reads as zero regardless of what is written to it.
    localparam rf_addr_t RF_ZERO_ADDR = '0;

endpackage

// File: rtl/rf_read_port_ctrl_if.sv
// Request/response bus of one regfile read port.
// Purpose : bundles the tagged read-request channel and the tagged
//           read-response channel between issue logic and the controller.
// Signals : REQ_VALID/REQ_READY/REQ_ADDR/REQ_TAG  request channel
//           RSP_VALID/RSP_READY/RSP_DATA/RSP_TAG  response channel
// Modports: master = issue logic, slave = rf_read_port_ctrl.
//
// Handshake rule (both channels): a transfer happens on a rising CLK edge
// where VALID and READY are both high. Once VALID is raised the sender keeps
// VALID and its payload stable until that transfer; READY may change freely
// and the receiver never waits on VALID before raising READY. The only
// exception is FLUSH, which withdraws pending responses.
interface rf_read_port_ctrl_if
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int TAG_WIDTH  = RF_TAG_WIDTH
);

    logic                  REQ_VALID;
    logic                  REQ_READY;
    logic [ADDR_WIDTH-1:0] REQ_ADDR;
    logic [TAG_WIDTH-1:0]  REQ_TAG;

    logic                  RSP_VALID;
    logic                  RSP_READY;
    logic [DATA_WIDTH-1:0] RSP_DATA;
    logic [TAG_WIDTH-1:0]  RSP_TAG;

    modport master (
        output REQ_VALID, REQ_ADDR, REQ_TAG, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_TAG
    );

    modport slave (
        input  REQ_VALID, REQ_ADDR, REQ_TAG, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_TAG
    );

endinterface

// File: rtl/rf_rsp_fifo.sv
// In-order response buffer for the regfile read port.
// Purpose : DEPTH-entry FIFO of {tag,data}; pointers wrap modulo DEPTH so
//           any DEPTH >= 2 works, not only powers of two.
// Ports   : CLK, RST_N (async active-low), FLUSH (sync clear),
//           PUSH/PUSH_DATA write side, POP read side,
//           HEAD_DATA oldest entry, OCC entry count 0..DEPTH.
// The caller guarantees no push when full and no pop when empty.
module rf_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 36
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       FLUSH,
    input  logic                       PUSH,
    input  logic [WIDTH-1:0]           PUSH_DATA,
    input  logic                       POP,
    output logic [WIDTH-1:0]           HEAD_DATA,
    output logic [$clog2(DEPTH+1)-1:0] OCC
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [OW-1:0]    occ_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (PUSH) begin
                mem[wr_ptr] <= PUSH_DATA;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (POP) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({PUSH, POP})
                2'b10:   occ_q <= occ_q + OW'(1);
                2'b01:   occ_q <= occ_q - OW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign HEAD_DATA = mem[rd_ptr];
    assign OCC       = occ_q;

endmodule

// File: rtl/rf_read_port_ctrl.sv
// Read-port controller for one port of the multi-port register file
// (synchronous read, read-old-data array).
// Purpose : accepts tagged read requests, drives RF_RE/RF_RADDR, captures
//           RF_DOUT the following cycle, substitutes same-cycle write-port
//           data the array read misses, and returns tagged responses in
//           order through a small buffer.
// Ports   : CLK, RST_N (async active-low), FLUSH (sync discard)
//           bus      request/response channels (slave side)
//           RF_RE, RF_RADDR, RF_DOUT      regfile read port
//           WB_WE, WB_WADDR, WB_DIN       snooped regfile write ports
// Timing  : request accepted in cycle t, data captured at the end of t+1,
//           RSP_VALID from cycle t+2.
module rf_read_port_ctrl
    import rf_pkg::*;
#(
    parameter int ROWS       = RF_ROWS,
    parameter int ADDR_WIDTH = $clog2(ROWS),
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int WP         = 3,
    parameter int TAG_WIDTH  = RF_TAG_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               FLUSH,
    rf_read_port_ctrl_if.slave                 bus,
    output logic                               RF_RE,
    output logic [ADDR_WIDTH-1:0]              RF_RADDR,
    input  logic [DATA_WIDTH-1:0]              RF_DOUT,
    input  logic [WP-1:0]                      WB_WE,
    input  logic [WP-1:0][ADDR_WIDTH-1:0]      WB_WADDR,
    input  logic [WP-1:0][DATA_WIDTH-1:0]      WB_DIN
);

    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = OW + 1;
    localparam int EW = TAG_WIDTH + DATA_WIDTH;

    logic                  accept;
    logic                  pop;
    logic                  push;
    logic [OW-1:0]         occ;
    logic [CW-1:0]         credit_used;
    logic [EW-1:0]         head_data;
    logic [EW-1:0]         push_data;

    // Forwarding snapshot taken in the accept cycle.
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    // Read in flight between accept (t) and capture (t+1).
    logic                  inflight_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic                  zero_q;
    logic                  hit_q;
    logic [DATA_WIDTH-1:0] fdata_q;
    logic [DATA_WIDTH-1:0] cap_data;

    assign pop = bus.RSP_VALID & bus.RSP_READY;

    // Slots committed: buffered entries plus the read in flight, minus the
    // entry leaving this cycle. Counting the pop lets a full-minus-one
    // buffer keep accepting one request per cycle while draining.
    assign credit_used = CW'(occ) + CW'(inflight_q) - CW'(pop);

    assign bus.REQ_READY = RST_N & !FLUSH & (credit_used < CW'(DEPTH));
    assign accept        = bus.REQ_VALID & bus.REQ_READY;

    assign RF_RE    = accept;
    assign RF_RADDR = RST_N ? bus.REQ_ADDR : '0;

    // The array returns pre-write data for a same-cycle write, so pick up
    // the snooped write instead. Later ports overwrite earlier ones in the
    // array, so the highest matching port wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WP; i++) begin
            if (WB_WE[i] && (WB_WADDR[i] == bus.REQ_ADDR)) begin
                fwd_hit  = 1'b1;
                fwd_data = WB_DIN[i];
            end
        end
    end

    // A new accept always overwrites the in-flight slot; FLUSH blocks
    // accept, so the in-flight read is dropped in the flush cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            inflight_q <= 1'b0;
            tag_q      <= '0;
            zero_q     <= 1'b0;
            hit_q      <= 1'b0;
            fdata_q    <= '0;
        end else begin
            inflight_q <= accept;
            if (accept) begin
                tag_q   <= bus.REQ_TAG;
                zero_q  <= (bus.REQ_ADDR == ADDR_WIDTH'(RF_ZERO_ADDR));
                hit_q   <= fwd_hit;
                fdata_q <= fwd_data;
            end
        end
    end

    // Writes after the accept cycle are deliberately not reflected.
    always_comb begin
        cap_data = RF_DOUT;
        if (zero_q) begin
            cap_data = '0;
        end else if (hit_q) begin
            cap_data = fdata_q;
        end
    end

    assign push      = inflight_q & !FLUSH;
    assign push_data = {tag_q, cap_data};

    rf_rsp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_rsp_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .FLUSH     (FLUSH),
        .PUSH      (push),
        .PUSH_DATA (push_data),
        .POP       (pop),
        .HEAD_DATA (head_data),
        .OCC       (occ)
    );

    assign bus.RSP_VALID = (occ != '0);
    assign bus.RSP_DATA  = bus.RSP_VALID ? head_data[DATA_WIDTH-1:0] : '0;
    assign bus.RSP_TAG   = bus.RSP_VALID ? head_data[DATA_WIDTH +: TAG_WIDTH] : '0;

endmodule

// File: tb/tb_rf_read_port_ctrl.sv
// Testbench for rf_read_port_ctrl: driver tasks issue directed reads with
// hand-computed expected results into exp_q; a negedge monitor pops and
// compares every response handshake and checks hold stability.
module tb_rf_read_port_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int WP = 3;
    localparam int W  = TW + DW;

    logic                  CLK;
    logic                  RST_N;
    logic                  FLUSH;
    logic                  RF_RE;
    logic [AW-1:0]         RF_RADDR;
    logic [DW-1:0]         RF_DOUT;
    logic [WP-1:0]         WB_WE;
    logic [WP-1:0][AW-1:0] WB_WADDR;
    logic [WP-1:0][DW-1:0] WB_DIN;

    rf_read_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    rf_read_port_ctrl #(
        .ROWS(32), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WP(WP), .TAG_WIDTH(TW), .DEPTH(2)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .FLUSH    (FLUSH),
        .bus      (bus),
        .RF_RE    (RF_RE),
        .RF_RADDR (RF_RADDR),
        .RF_DOUT  (RF_DOUT),
        .WB_WE    (WB_WE),
        .WB_WADDR (WB_WADDR),
        .WB_DIN   (WB_DIN)
    );

    // ---------------- clock / cycle counter ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- regfile model (sync read, read-old-data) ----------------
    logic [DW-1:0] mem [32];
    always @(posedge CLK) begin
        if (RF_RE) RF_DOUT <= mem[RF_RADDR];
        for (int i = 0; i < WP; i++) begin
            if (WB_WE[i]) mem[WB_WADDR[i]] <= WB_DIN[i];
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int pop_cyc_q[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic          hold_chk = 1'b0;
    logic [DW-1:0] hold_data;
    logic [TW-1:0] hold_tag;
    logic [W-1:0]  exp_e;

    always @(negedge CLK) begin
        if (!RST_N) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("hold_valid", 32'(bus.RSP_VALID), 32'd1);
                chk("hold_data", bus.RSP_DATA, hold_data);
                chk("hold_tag", 32'(bus.RSP_TAG), 32'(hold_tag));
            end
            hold_chk  = bus.RSP_VALID & !bus.RSP_READY & !FLUSH;
            hold_data = bus.RSP_DATA;
            hold_tag  = bus.RSP_TAG;
            if (bus.RSP_VALID && bus.RSP_READY) begin
                pop_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual tag=%h data=%h required no response",
                             bus.RSP_TAG, bus.RSP_DATA);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("rsp_tag", 32'(bus.RSP_TAG), 32'(exp_e[DW +: TW]));
                    chk("rsp_data", bus.RSP_DATA, exp_e[DW-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Offer a request until accepted (bounded); leaves REQ_VALID low.
    task automatic issue(input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                         input logic [DW-1:0] exp, input bit expect_rsp);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        bus.REQ_VALID = 1'b1;
        bus.REQ_ADDR  = addr;
        bus.REQ_TAG   = tag;
        while (!ok && n < 50) begin
            @(negedge CLK);
            if (bus.REQ_READY) begin
                ok = 1'b1;
                chk("rf_re", 32'(RF_RE), 32'd1);
                chk("rf_raddr", 32'(RF_RADDR), 32'(addr));
                if (expect_rsp) exp_q.push_back({tag, exp});
            end
            step();
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_timeout actual=not accepted required=accepted addr=%0d", addr);
        end
        bus.REQ_VALID = 1'b0;
        WB_WE         = '0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int c0;
    int rdy_seen;

    initial begin
        RST_N         = 1'b0;
        FLUSH         = 1'b0;
        bus.REQ_VALID = 1'b1;
        bus.REQ_ADDR  = 5'd3;
        bus.REQ_TAG   = '0;
        bus.RSP_READY = 1'b0;
        WB_WE         = '0;
        WB_WADDR      = '0;
        WB_DIN        = '0;

        // Preload the array model through write port 0 while in reset.
        for (int i = 0; i < 32; i++) begin
            step();
            WB_WE       = 3'b001;
            WB_WADDR[0] = 5'(i);
            WB_DIN[0]   = (i == 5) ? 32'hDEAD_BEEF :
                          (i == 7) ? 32'hAAAA_0000 : (32'hC0DE_0000 | 32'(i));
        end
        step();
        WB_WE = '0;

        // Reset values with a request being offered.
        @(negedge CLK);
        chk("rst_req_ready", 32'(bus.REQ_READY), 32'd0);
        chk("rst_rf_re", 32'(RF_RE), 32'd0);
        chk("rst_rf_raddr", 32'(RF_RADDR), 32'd0);
        chk("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        chk("rst_rsp_data", bus.RSP_DATA, 32'd0);
        chk("rst_rsp_tag", 32'(bus.RSP_TAG), 32'd0);
        step();
        bus.REQ_VALID = 1'b0;
        RST_N         = 1'b1;
        bus.RSP_READY = 1'b1;
        step();
        @(negedge CLK);
        chk("idle_req_ready", 32'(bus.REQ_READY), 32'd1);
        step();

        // Basic read of r5 with latency check.
        issue(5'd5, 4'h3, 32'hDEAD_BEEF, 1'b1);
        @(negedge CLK);
        chk("lat_t1_valid", 32'(bus.RSP_VALID), 32'd0);
        step();
        @(negedge CLK);
        chk("lat_t2_valid", 32'(bus.RSP_VALID), 32'd1);
        step();
        wait_drain();

        // Forwarding: p0 and p2 write r7 in the accept cycle, p2 wins;
        // the write one cycle later must not leak into this response.
        WB_WE       = 3'b101;
        WB_WADDR[0] = 5'd7;
        WB_WADDR[1] = 5'd7;
        WB_WADDR[2] = 5'd7;
        WB_DIN[0]   = 32'h11;
        WB_DIN[1]   = 32'h99;
        WB_DIN[2]   = 32'h22;
        issue(5'd7, 4'h5, 32'h22, 1'b1);
        WB_WE       = 3'b001;
        WB_WADDR[0] = 5'd7;
        WB_DIN[0]   = 32'h33;
        step();
        WB_WE = '0;
        wait_drain();
        issue(5'd7, 4'h6, 32'h33, 1'b1);
        wait_drain();

        // r0 reads zero even when written, and after the write lands.
        WB_WE       = 3'b010;
        WB_WADDR[1] = 5'd0;
        WB_DIN[1]   = 32'hFFFF_FFFF;
        issue(5'd0, 4'h1, 32'h0, 1'b1);
        issue(5'd0, 4'h2, 32'h0, 1'b1);
        wait_drain();

        // Back-to-back 8 reads, one per cycle, responses on consecutive cycles.
        pop_cyc_q.delete();
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            issue(5'(8 + i), 4'(i), 32'hC0DE_0000 | 32'(8 + i), 1'b1);
        end
        chk("b2b_issue_cycles", 32'(cyc - c0), 32'd8);
        wait_drain();
        step();
        chk("b2b_rsp_count", 32'(pop_cyc_q.size()), 32'd8);
        if (pop_cyc_q.size() == 8) begin
            chk("b2b_rsp_span", 32'(pop_cyc_q[7] - pop_cyc_q[0]), 32'd7);
        end

        // Backpressure: two accepts fill the credit, then REQ_READY stays low.
        bus.RSP_READY = 1'b0;
        issue(5'd20, 4'h9, 32'hC0DE_0014, 1'b1);
        issue(5'd21, 4'hA, 32'hC0DE_0015, 1'b1);
        bus.REQ_VALID = 1'b1;
        bus.REQ_ADDR  = 5'd22;
        bus.REQ_TAG   = 4'hB;
        rdy_seen      = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (bus.REQ_READY) rdy_seen++;
            chk("bp_rf_re", 32'(RF_RE), 32'd0);
            step();
        end
        chk("bp_ready_seen", 32'(rdy_seen), 32'd0);
        chk("bp_head_tag", 32'(bus.RSP_TAG), 32'h9);
        bus.RSP_READY = 1'b1;
        issue(5'd22, 4'hB, 32'hC0DE_0016, 1'b1);
        issue(5'd23, 4'hC, 32'hC0DE_0017, 1'b1);
        wait_drain();

        // FLUSH with one buffered and one in flight: nothing may come out.
        bus.RSP_READY = 1'b0;
        issue(5'd24, 4'h1, 32'h0, 1'b0);
        issue(5'd25, 4'h2, 32'h0, 1'b0);
        FLUSH = 1'b1;
        step();
        bus.REQ_VALID = 1'b1;
        bus.REQ_ADDR  = 5'd26;
        bus.REQ_TAG   = 4'h3;
        @(negedge CLK);
        chk("fl_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        chk("fl_req_ready", 32'(bus.REQ_READY), 32'd0);
        chk("fl_rf_re", 32'(RF_RE), 32'd0);
        step();
        FLUSH         = 1'b0;
        bus.REQ_VALID = 1'b0;
        bus.RSP_READY = 1'b1;
        pop_cyc_q.delete();
        repeat (4) step();
        chk("fl_no_rsp", 32'(pop_cyc_q.size()), 32'd0);
        issue(5'd5, 4'h7, 32'hDEAD_BEEF, 1'b1);
        @(negedge CLK);
        chk("fl_lat_t1_valid", 32'(bus.RSP_VALID), 32'd0);
        step();
        @(negedge CLK);
        chk("fl_lat_t2_valid", 32'(bus.RSP_VALID), 32'd1);
        step();
        wait_drain();

        // Async reset with one buffered and one in flight.
        bus.RSP_READY = 1'b0;
        issue(5'd9, 4'h3, 32'h0, 1'b0);
        step();
        issue(5'd10, 4'h4, 32'h0, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        chk("arst_req_ready", 32'(bus.REQ_READY), 32'd0);
        step();
        RST_N         = 1'b1;
        bus.RSP_READY = 1'b1;
        pop_cyc_q.delete();
        repeat (4) step();
        chk("arst_no_rsp", 32'(pop_cyc_q.size()), 32'd0);
        issue(5'd9, 4'h5, 32'hC0DE_0009, 1'b1);
        wait_drain();

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
